desroteador: RTL and testbench



---
 rtl/desroteador_pkg.sv | 15 +
 rtl/desroteador_fifo_saida.sv | 64 ++++++
 rtl/desroteador.sv | 96 +++++++++
 tb/tb_desroteador.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/desroteador_pkg.sv
// Shared widths, word type and destination encoding for the desroteador slice.
package desroteador_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned DEPTH_DEF = 2;
    localparam int unsigned CNT_W_DEF = 8;

    typedef logic [WIDTH_DEF-1:0] palavra_t;

    typedef enum logic {
        DEST_A = 1'b0,
        DEST_B = 1'b1
    } destino_t;

endpackage

// File: rtl/desroteador_fifo_saida.sv
// Per-output FIFO: registered storage, wrapping pointers, occupancy count.
// Head reads as zero while empty, so nothing stale is ever presented.
module fifo_saida #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == C_DEPTH);
    assign valid  = (r_count != '0);
    assign w_push = push && !full;
    assign w_pop  = pop && valid;
    assign dout   = valid ? r_mem[r_rd_ptr] : '0;
    assign count  = r_count;

    // Storage write; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/desroteador.sv
// 1-to-2 stream distributor: steers each input word to FIFO A or B by SEL
// and counts words delivered on each output.
module desroteador
    import desroteador_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             SEL,
    input  logic             ent_valid,
    output logic             ent_ready,
    output logic [WIDTH-1:0] SaidaA,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] SaidaB,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

    destino_t         w_sel;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_full_a;
    logic             w_full_b;
    logic [OCC_W-1:0] w_count_a;
    logic [OCC_W-1:0] w_count_b;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    assign w_sel = destino_t'(SEL);

    // Readiness depends only on registered occupancy of the selected FIFO.
    assign ent_ready = (w_sel == DEST_B) ? (w_count_b < C_DEPTH)
                                         : (w_count_a < C_DEPTH);

    assign w_push_a = ent_valid && (w_sel == DEST_A) && !w_full_a;
    assign w_push_b = ent_valid && (w_sel == DEST_B) && !w_full_b;

    fifo_saida #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_a),
        .din   (Entrada),
        .full  (w_full_a),
        .pop   (a_ready),
        .dout  (SaidaA),
        .valid (a_valid),
        .count (w_count_a)
    );

    fifo_saida #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_b),
        .din   (Entrada),
        .full  (w_full_b),
        .pop   (b_ready),
        .dout  (SaidaB),
        .valid (b_valid),
        .count (w_count_b)
    );

    // Delivered-word counters; wrap freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (a_valid && a_ready) begin
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            end
            if (b_valid && b_ready) begin
                r_cnt_b <= r_cnt_b + CNT_W'(1);
            end
        end
    end

    assign cntA = r_cnt_a;
    assign cntB = r_cnt_b;

endmodule

// File: tb/tb_desroteador.sv
// Self-checking bench for desroteador: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_desroteador;
    import desroteador_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    palavra_t   Entrada;
    logic       SEL;
    logic       ent_valid;
    logic       ent_ready;
    palavra_t   SaidaA;
    logic       a_valid;
    logic       a_ready;
    palavra_t   SaidaB;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] cntA;
    logic [7:0] cntB;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per output and plain delivered counts.
    palavra_t   qa[$];
    palavra_t   qb[$];
    logic [7:0] ca;
    logic [7:0] cb;

    desroteador dut (
        .clk       (clk),
        .reset     (reset),
        .Entrada   (Entrada),
        .SEL       (SEL),
        .ent_valid (ent_valid),
        .ent_ready (ent_ready),
        .SaidaA    (SaidaA),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .SaidaB    (SaidaB),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .cntA      (cntA),
        .cntB      (cntB)
    );

    always #5 clk = ~clk;

    // Producer rule: a stalled word must be held unchanged until accepted.
    logic     r_stall = 1'b0;
    logic     r_sel   = 1'b0;
    palavra_t r_dat   = '0;
    always @(posedge clk) begin
        if (r_stall && !reset) begin
            n_vec++;
            if (!ent_valid || SEL !== r_sel || Entrada !== r_dat) begin
                n_err++;
                $display("FAIL hold: valid=%b sel=%b data=%h, required 1 %b %h",
                         ent_valid, SEL, Entrada, r_sel, r_dat);
            end
        end
        r_stall <= ent_valid && !ent_ready && !reset;
        r_sel   <= SEL;
        r_dat   <= Entrada;
    end

    function automatic logic exp_ready();
        return SEL ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    endfunction

    function automatic palavra_t exp_head_a();
        return (qa.size() > 0) ? qa[0] : palavra_t'(0);
    endfunction

    function automatic palavra_t exp_head_b();
        return (qb.size() > 0) ? qb[0] : palavra_t'(0);
    endfunction

    task automatic drive(input logic v, input logic s, input palavra_t d,
                         input logic ar, input logic br);
        ent_valid = v;
        SEL       = s;
        Entrada   = d;
        a_ready   = ar;
        b_ready   = br;
        #1;
    endtask

    // Advance one cycle, updating the model from the inputs presented now.
    task automatic clock();
        logic     acc, pa, pb, s;
        palavra_t d;
        acc = ent_valid && exp_ready();
        pa  = a_ready && (qa.size() > 0);
        pb  = b_ready && (qb.size() > 0);
        s   = SEL;
        d   = Entrada;
        @(posedge clk);
        if (pa) begin void'(qa.pop_front()); ca = ca + 8'd1; end
        if (pb) begin void'(qb.pop_front()); cb = cb + 8'd1; end
        if (acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        reset = 1'b1;
        qa.delete(); qb.delete(); ca = '0; cb = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({a_valid, b_valid, cntA, cntB, SaidaA, SaidaB, ent_ready} !== {1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: av=%b bv=%b cA=%h cB=%h sA=%h sB=%h rdy=%b, required 0 0 00 00 0 0 1",
                     a_valid, b_valid, cntA, cntB, SaidaA, SaidaB, ent_ready);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0); clock();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0); clock();
        drive(1'b1, 1'b0, 4'hA, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b0, 4'hB, 1'b0, 1'b0); clock();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        n_vec++;
        if (a_valid !== 1'b1 || cntA !== 8'h01) begin
            n_err++;
            $display("FAIL mid_preload: av=%b cA=%h, required 1 01", a_valid, cntA);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (a_valid !== 1'b0 || cntA !== 8'h00 || SaidaA !== 4'h0) begin
            n_err++;
            $display("FAIL mid_async_reset: av=%b cA=%h sA=%h, required 0 00 0", a_valid, cntA, SaidaA);
        end
        qa.delete(); qb.delete(); ca = '0; cb = '0;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'h5, 1'b0, 1'b0); clock();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        n_vec++;
        if (a_valid !== 1'b1 || SaidaA !== 4'h5) begin
            n_err++;
            $display("FAIL mid_first_after: av=%b sA=%h, required 1 5", a_valid, SaidaA);
        end
    endtask

    task automatic test_steering();
        apply_reset();
        drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b1); clock();
        n_vec++;
        if (a_valid !== 1'b1 || SaidaA !== 4'h3 || b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL steer_a: av=%b sA=%h bv=%b, required 1 3 0", a_valid, SaidaA, b_valid);
        end
        drive(1'b1, 1'b1, 4'hC, 1'b1, 1'b1); clock();
        n_vec++;
        if (b_valid !== 1'b1 || SaidaB !== 4'hC || a_valid !== 1'b0 || cntA !== 8'h01) begin
            n_err++;
            $display("FAIL steer_b: bv=%b sB=%h av=%b cA=%h, required 1 c 0 01", b_valid, SaidaB, a_valid, cntA);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1); clock();
        n_vec++;
        if (cntA !== 8'h01 || cntB !== 8'h01 || b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL steer_counts: cA=%h cB=%h bv=%b, required 01 01 0", cntA, cntB, b_valid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        n_vec++;
        if (ent_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full_ready: got %b, required 0", ent_ready);
        end
        clock();
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b1);
        n_vec++;
        if (ent_ready !== 1'b0 || SaidaB !== 4'h1) begin
            n_err++;
            $display("FAIL bp_no_cut_through: rdy=%b sB=%h, required 0 1", ent_ready, SaidaB);
        end
        clock();
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b1);
        n_vec++;
        if (ent_ready !== 1'b1 || SaidaB !== 4'h2) begin
            n_err++;
            $display("FAIL bp_second: rdy=%b sB=%h, required 1 2", ent_ready, SaidaB);
        end
        clock();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        n_vec++;
        if (SaidaB !== 4'h3 || b_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_third: sB=%h bv=%b, required 3 1", SaidaB, b_valid);
        end
        clock();
        n_vec++;
        if (b_valid !== 1'b0 || cntB !== 8'h03) begin
            n_err++;
            $display("FAIL bp_drained: bv=%b cB=%h, required 0 03", b_valid, cntB);
        end
    endtask

    task automatic test_independence();
        apply_reset();
        drive(1'b1, 1'b1, 4'hD, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b1, 4'hE, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
        n_vec++;
        if (ent_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ind_b_full: rdy=%b, required 0", ent_ready);
        end
        drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        n_vec++;
        if (ent_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ind_a_ready: rdy=%b, required 1", ent_ready);
        end
        clock();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        n_vec++;
        if (SaidaA !== 4'h9 || a_valid !== 1'b1 || b_valid !== 1'b1 || SaidaB !== 4'hD || cntB !== 8'h00) begin
            n_err++;
            $display("FAIL ind_state: sA=%h av=%b bv=%b sB=%h cB=%h, required 9 1 1 d 00",
                     SaidaA, a_valid, b_valid, SaidaB, cntB);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive(1'b1, 1'b0, 4'h4, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
        n_vec++;
        if (ent_ready !== 1'b1) begin
            n_err++;
            $display("FAIL simul_ready: rdy=%b, required 1", ent_ready);
        end
        clock();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        n_vec++;
        if (SaidaA !== 4'h7 || a_valid !== 1'b1 || cntA !== 8'h01) begin
            n_err++;
            $display("FAIL simul_head: sA=%h av=%b cA=%h, required 7 1 01", SaidaA, a_valid, cntA);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0); clock();
        n_vec++;
        if (a_valid !== 1'b0 || cntA !== 8'h02) begin
            n_err++;
            $display("FAIL simul_occupancy: av=%b cA=%h, required 0 02", a_valid, cntA);
        end
        // Full FIFO with a pop in the same cycle still refuses the push.
        drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0); clock();
        drive(1'b1, 1'b0, 4'h8, 1'b1, 1'b0);
        n_vec++;
        if (ent_ready !== 1'b0) begin
            n_err++;
            $display("FAIL simul_full_reject: rdy=%b, required 0", ent_ready);
        end
        clock();
        drive(1'b1, 1'b0, 4'h8, 1'b0, 1'b0);
        n_vec++;
        if (ent_ready !== 1'b1 || SaidaA !== 4'h2) begin
            n_err++;
            $display("FAIL simul_after_pop: rdy=%b sA=%h, required 1 2", ent_ready, SaidaA);
        end
        clock();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0); clock();
        n_vec++;
        if (SaidaA !== 4'h8) begin
            n_err++;
            $display("FAIL simul_held_word: sA=%h, required 8", SaidaA);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, palavra_t'($urandom_range(15)), 1'b1, 1'b0);
            clock();
            n_vec++;
            if (cntA !== ca) begin
                n_err++;
                $display("FAIL wrap_count[%0d]: got %h, required %h", i, cntA, ca);
            end
        end
        n_vec++;
        if (cntA !== 8'hFF) begin
            n_err++;
            $display("FAIL wrap_top: got %h, required ff", cntA);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0); clock();
        n_vec++;
        if (cntA !== 8'h00 || cntB !== 8'h00 || a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_zero: cA=%h cB=%h av=%b, required 00 00 0", cntA, cntB, a_valid);
        end
    endtask

    task automatic test_random();
        logic     stalled = 1'b0;
        logic     v = 1'b0, s = 1'b0;
        palavra_t d = '0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                v = ($urandom_range(3) != 0);
                s = 1'($urandom_range(1));
                d = palavra_t'($urandom_range(15));
            end
            drive(v, s, d, ($urandom_range(2) != 0), ($urandom_range(3) == 0));
            n_vec++;
            if (ent_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b, required %b", i, ent_ready, exp_ready());
            end
            stalled = v && !exp_ready();
            clock();
            n_vec++;
            if ({a_valid, b_valid, SaidaA, SaidaB, cntA, cntB} !==
                {(qa.size() > 0), (qb.size() > 0), exp_head_a(), exp_head_b(), ca, cb}) begin
                n_err++;
                $display("FAIL rand_out[%0d]: av=%b bv=%b sA=%h sB=%h cA=%h cB=%h, required %b %b %h %h %h %h",
                         i, a_valid, b_valid, SaidaA, SaidaB, cntA, cntB,
                         (qa.size() > 0), (qb.size() > 0), exp_head_a(), exp_head_b(), ca, cb);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_reset_mid();
        test_steering();
        test_backpressure();
        test_independence();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
